pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter CH, default 4, number of PWM output channels (1..16).
REQ-002 Parameter W, default 8, counter, period and duty width (4..16).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  run control; 0 halts and idles the block.
REQ-006 period  input  W  terminal count P.
REQ-007 duty  input  CH*W  per-channel compare value D[i], channel i at bits [i*W +: W].
REQ-008 pre  input  2  prescaler select: tick every 2^pre clocks (1/2/4/8).
REQ-009 mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-010 pol  input  CH  per-channel polarity; output = raw compare XOR pol[i].
REQ-011 upd  input  1  one-cycle request to load period/duty/pre/mode into shadows.
REQ-012 upd_done  output  1  one-cycle pulse when requested shadows are loaded.
REQ-013 period_end  output  1  one-cycle pulse at every period boundary.
REQ-014 pwmout  output  CH  registered PWM outputs.

Function
REQ-015 Counting SHALL use only the shadow copies (P_s, D_s, pre_s, mode_s); pol is used live.
REQ-016 The prescaler SHALL assert one internal tick every 2^pre_s clocks; the counter advances only on ticks.
REQ-017 Edge mode: the counter SHALL count 0..P_s and then wrap to 0, giving P_s+1 ticks per period.
REQ-018 Center mode: the counter SHALL count up 0..P_s and then down to 1, giving 2*P_s ticks per period.
REQ-019 Center mode with P_s=0: the counter SHALL stay at 0 and every tick SHALL be a boundary.
REQ-020 Raw compare for channel i SHALL be (cnt < D_s[i]), an unsigned W-bit compare.
REQ-021 D_s[i]=0 SHALL give a constant-low raw compare.
REQ-022 D_s[i] > P_s SHALL give a constant-high raw compare in edge mode.
REQ-023 pwmout SHALL be registered every clock from the current cnt, giving one clock of latency from cnt to pin.
REQ-024 Boundary SHALL be the tick on which cnt returns to 0 (edge: cnt==P_s; center: descending cnt==1); period_end SHALL pulse in that clock.
REQ-025 upd SHALL set a pending flag; at the next boundary, shadows SHALL load from the inputs, pending SHALL clear and upd_done SHALL pulse in the same clock as period_end.
REQ-026 upd coincident with a boundary SHALL load at that boundary.
REQ-027 upd while already pending SHALL NOT queue a second load.
REQ-028 Inputs SHALL be sampled only at the load clock; no partial-period update is permitted.
REQ-029 While enable=0: the prescaler and cnt SHALL be held at 0 and counting up, shadows SHALL track the inputs every clock, pending SHALL clear, pwmout SHALL equal pol, and no pulses SHALL be issued.
REQ-030 When enable rises, the first tick SHALL occur 2^pre_s clocks later and counting SHALL start from cnt=0.

Reset
REQ-031 rst=1 SHALL asynchronously force cnt=0, prescaler=0, direction=up, pending=0, shadows=0, upd_done=0, period_end=0 and pwmout=pol.
REQ-032 Reset asserted mid-period SHALL abandon the period and any pending update, with no pulses issued.

Structure
REQ-033 Package pwm_pkg SHALL hold the mode encoding constants (MODE_EDGE, MODE_CENTER) and the prescaler-decode function.
REQ-034 The prescaler SHALL be sub-module pwm_prescaler (inputs clk, rst, clr, pre; output tick); counter, shadows and compare SHALL stay in pwm_multi.

Verification
REQ-035 Edge test: W=8, P=199, D[0]=150, pre=0 -> pwmout[0] is high 150 clocks and low 50 clocks, period_end pulses every 200 clocks.
REQ-036 Center test: P=4, D[0]=2, pre=0 -> cnt runs 0,1,2,3,4,3,2,1; pwmout[0] is high 3 of every 8 clocks; period_end pulses every 8 clocks.
REQ-037 Prescaler test: pre=2, P=9, D=5 -> 40-clock period with 20 clocks high, and pwmout changes only on 4-clock boundaries.
REQ-038 Update test: upd with D[0]=50 at cnt=100 (P=199) -> the current period keeps 150 high; upd_done coincides with period_end; the next period is 50 high.
REQ-039 Boundary test: D=0 -> constant low; D=255 with P=199 -> constant high; pol=1 -> both levels inverted.
REQ-040 Reset/enable test: rst mid-period -> pwmout=pol in the same cycle and pending is lost; enable=0 -> outputs idle at pol and no pulses are issued.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Terminal value of the prescaler divider: 2^pre clocks per tick.
  function automatic logic [2:0] pre_limit(input logic [1:0] pre);
    case (pre)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider producing one tick every 2^pre clocks; clr holds it at phase 0.
module pwm_prescaler
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] pre,
  output logic       tick
);

  logic [2:0] div;

  // Tick on the last clock of each prescaler window.
  always_comb begin
    tick = 1'b0;
    if (!clr && (div == pre_limit(pre))) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // Divider restarts after every tick so each window begins at phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= 3'd0;
    end else if (clr || tick) begin
      div <= 3'd0;
    end else begin
      div <= div + 3'd1;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shadowed period/duty/prescale/mode and edge or center alignment.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [W-1:0]  period,
  input  logic [CH*W-1:0] duty,
  input  logic [1:0]    pre,
  input  logic          mode,
  input  logic [CH-1:0] pol,
  input  logic          upd,
  output logic          upd_done,
  output logic          period_end,
  output logic [CH-1:0] pwmout
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]    cnt;
  logic            down;
  logic            pending;
  logic [W-1:0]    period_s;
  logic [CH*W-1:0] duty_s;
  logic [1:0]      pre_s;
  logic            mode_s;
  logic [CH-1:0]   raw;
  logic [CH-1:0]   raw_next;
  logic [W-1:0]    cnt_next;
  logic            down_next;
  logic            wrap;
  logic            tick;
  logic            boundary;
  logic            load;

  pwm_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (~enable),
    .pre  (pre_s),
    .tick (tick)
  );

  // Next counter value and whether this tick closes the period.
  always_comb begin
    cnt_next  = cnt;
    down_next = down;
    wrap      = 1'b0;
    if (mode_s == MODE_EDGE) begin
      if (cnt == period_s) begin
        wrap     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + ONE;
      end
    end else if (!down) begin
      // A peak of 0 or 1 has no descending leg, so the peak itself closes the period.
      if ((cnt == period_s) && (period_s <= ONE)) begin
        wrap     = 1'b1;
        cnt_next = '0;
      end else if (cnt == period_s) begin
        down_next = 1'b1;
        cnt_next  = cnt - ONE;
      end else begin
        cnt_next = cnt + ONE;
      end
    end else begin
      if (cnt <= ONE) begin
        wrap      = 1'b1;
        cnt_next  = '0;
        down_next = 1'b0;
      end else begin
        cnt_next = cnt - ONE;
      end
    end
  end

  assign boundary = tick & wrap;
  assign load     = boundary & (pending | upd);

  // Unsigned per-channel compare against the current count.
  always_comb begin
    raw_next = '0;
    for (int i = 0; i < CH; i++) begin
      raw_next[i] = (cnt < duty_s[i*W +: W]);
    end
  end

  // Counter, direction, shadows, pending flag and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      down       <= 1'b0;
      pending    <= 1'b0;
      period_s   <= '0;
      duty_s     <= '0;
      pre_s      <= 2'd0;
      mode_s     <= MODE_EDGE;
      raw        <= '0;
      period_end <= 1'b0;
      upd_done   <= 1'b0;
    end else if (!enable) begin
      cnt        <= '0;
      down       <= 1'b0;
      pending    <= 1'b0;
      period_s   <= period;
      duty_s     <= duty;
      pre_s      <= pre;
      mode_s     <= mode;
      raw        <= '0;
      period_end <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      raw        <= raw_next;
      period_end <= boundary;
      upd_done   <= load;
      if (tick) begin
        cnt  <= cnt_next;
        down <= down_next;
      end else begin
        cnt  <= cnt;
        down <= down;
      end
      if (boundary) begin
        pending <= 1'b0;
      end else if (upd) begin
        pending <= 1'b1;
      end else begin
        pending <= pending;
      end
      if (load) begin
        period_s <= period;
        duty_s   <= duty;
        pre_s    <= pre;
        mode_s   <= mode;
      end else begin
        period_s <= period_s;
        duty_s   <= duty_s;
        pre_s    <= pre_s;
        mode_s   <= mode_s;
      end
    end
  end

  // Polarity is applied live so reset and idle show pol immediately.
  assign pwmout = raw ^ pol;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized reconfiguration vs. a period-position model.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  period = '0;
  logic [CH*W-1:0] duty = '0;
  logic [1:0]    pre = 2'd0;
  logic          mode = 1'b0;
  logic [CH-1:0] pol = 4'b1010;
  logic          upd = 1'b0;
  logic          upd_done;
  logic          period_end;
  logic [CH-1:0] pwmout;

  int total = 0;
  int bad   = 0;

  // Model state: current period configuration and position (in clocks) within it.
  int            m_p, m_pre, m_mode, m_pos;
  int            m_d [CH];
  bit            m_pend;
  logic [CH-1:0] m_raw;
  logic          m_pe, m_ud;

  int hi [CH];
  int pe_n, ud_n;
  bit found;

  pwm_multi #(.CH(CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period     (period),
    .duty       (duty),
    .pre        (pre),
    .mode       (mode),
    .pol        (pol),
    .upd        (upd),
    .upd_done   (upd_done),
    .period_end (period_end),
    .pwmout     (pwmout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ticks_per_period(input int p, input int md);
    if (md == 0) return p + 1;
    if (p == 0) return 1;
    return 2 * p;
  endfunction

  function automatic int cnt_at(input int p, input int md, input int j);
    if (md == 0) return j;
    if (p == 0) return 0;
    return (j <= p) ? j : 2 * p - j;
  endfunction

  task automatic load_cfg();
    m_p    = int'(period);
    m_pre  = int'(pre);
    m_mode = int'(mode);
    for (int i = 0; i < CH; i++) m_d[i] = int'(duty[i*W +: W]);
  endtask

  task automatic model_reset();
    m_p = 0; m_pre = 0; m_mode = 0; m_pos = 0; m_pend = 0;
    for (int i = 0; i < CH; i++) m_d[i] = 0;
    m_raw = '0; m_pe = 1'b0; m_ud = 1'b0;
  endtask

  task automatic model_edge();
    int cur, len;
    if (!enable) begin
      load_cfg();
      m_pend = 0; m_pos = 0; m_raw = '0; m_pe = 1'b0; m_ud = 1'b0;
    end else begin
      cur = cnt_at(m_p, m_mode, m_pos >> m_pre);
      for (int i = 0; i < CH; i++) m_raw[i] = (cur < m_d[i]);
      len = ticks_per_period(m_p, m_mode) << m_pre;
      m_pos++;
      m_pe = 1'b0; m_ud = 1'b0;
      if (m_pos == len) begin
        m_pos = 0;
        m_pe  = 1'b1;
        if (m_pend || upd) begin
          load_cfg();
          m_ud = 1'b1;
        end
        m_pend = 0;
      end else if (upd) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      @(negedge clk);
      chk("pwmout", 32'(pwmout), 32'(m_raw ^ pol));
      chk("period_end", 32'(period_end), 32'(m_pe));
      chk("upd_done", 32'(upd_done), 32'(m_ud));
      for (int i = 0; i < CH; i++) hi[i] += int'(pwmout[i]);
      pe_n += int'(period_end);
      ud_n += int'(upd_done);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    pe_n = 0; ud_n = 0;
  endtask

  task automatic restart(input int p, input int d0, input int pr, input int md);
    enable = 1'b0;
    period = W'(p);
    duty[0 +: W] = W'(d0);
    pre = 2'(pr);
    mode = md[0];
    step(2);
    enable = 1'b1;
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    step(1);
    upd = 1'b0;
  endtask

  initial begin
    model_reset();
    clr_cnt();
    // Reset state
    @(negedge clk);
    chk("rst_pwmout", 32'(pwmout), 32'(pol));
    chk("rst_period_end", 32'(period_end), 32'd0);
    chk("rst_upd_done", 32'(upd_done), 32'd0);
    step(2);
    rst = 1'b0;
    pol = 4'b0000;
    step(3);

    // Edge mode: P=199, D0=150, D1=0, D2=255, D3=100
    duty = {8'd100, 8'd255, 8'd0, 8'd150};
    restart(199, 150, 0, 0);
    step(5);
    clr_cnt();
    step(200);
    chk("edge_hi0", 32'(hi[0]), 32'd150);
    chk("edge_pe", 32'(pe_n), 32'd1);
    chk("d0_low", 32'(hi[1]), 32'd0);
    chk("dmax_high", 32'(hi[2]), 32'd200);
    chk("edge_hi3", 32'(hi[3]), 32'd100);
    pol = 4'b0110;
    clr_cnt();
    step(200);
    chk("pol_d0", 32'(hi[1]), 32'd200);
    chk("pol_dmax", 32'(hi[2]), 32'd0);
    pol = 4'b0000;

    // Center mode: P=4, D0=2
    restart(4, 2, 0, 1);
    step(3);
    clr_cnt();
    step(8);
    chk("ctr_hi0", 32'(hi[0]), 32'd3);
    chk("ctr_pe", 32'(pe_n), 32'd1);
    step(16);

    // Prescaler: pre=2, P=9, D0=5
    restart(9, 5, 2, 0);
    step(7);
    clr_cnt();
    step(40);
    chk("pre_hi0", 32'(hi[0]), 32'd20);
    chk("pre_pe", 32'(pe_n), 32'd1);

    // Shadow update mid-period
    restart(199, 150, 0, 0);
    step(100);
    duty[0 +: W] = 8'd50;
    pulse_upd();
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(1);
      if (upd_done) found = 1;
    end
    chk("upd_seen", 32'(found), 32'd1);
    chk("upd_with_pe", 32'(period_end), 32'd1);
    clr_cnt();
    step(200);
    chk("upd_hi0", 32'(hi[0]), 32'd50);
    chk("upd_none", 32'(ud_n), 32'd0);
    // Double request yields a single load
    duty[0 +: W] = 8'd120;
    step(10);
    pulse_upd();
    step(20);
    pulse_upd();
    clr_cnt();
    step(400);
    chk("upd_single", 32'(ud_n), 32'd1);

    // Reset mid-period abandons pending update
    duty[0 +: W] = 8'd30;
    pulse_upd();
    step(5);
    pol = 4'b1001;
    rst = 1'b1;
    #1;
    chk("midrst_pwmout", 32'(pwmout), 32'(pol));
    chk("midrst_pe", 32'(period_end), 32'd0);
    model_reset();
    step(2);
    rst = 1'b0;
    clr_cnt();
    step(10);
    chk("midrst_no_upd", 32'(ud_n), 32'd0);

    // Idle while disabled
    enable = 1'b0;
    duty = {8'd255, 8'd255, 8'd255, 8'd255};
    period = 8'd3;
    pulse_upd();
    clr_cnt();
    step(20);
    chk("idle_pe", 32'(pe_n), 32'd0);
    chk("idle_ud", 32'(ud_n), 32'd0);
    chk("idle_pwm", 32'(pwmout), 32'(pol));

    // Randomized reconfiguration
    for (int r = 0; r < 30; r++) begin
      period = W'($urandom_range(0, 12));
      for (int i = 0; i < CH; i++) duty[i*W +: W] = W'($urandom_range(0, 15));
      pre  = 2'($urandom_range(0, 3));
      mode = 1'($urandom_range(0, 1));
      pol  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) enable = ~enable;
      else enable = 1'b1;
      if ($urandom_range(0, 1) == 1) pulse_upd();
      step($urandom_range(10, 150));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
